tx_bit_scheduler: RTL and testbench

TX_BIT_SCHEDULER -- requirements
Module: tx_bit_scheduler

---
 rtl/tx_bit_scheduler.sv | 151 +++++++++++++++
 tb/tb_tx_bit_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_bit_scheduler.sv
// USB transmit bit-period scheduler: paces data bits, stuff bits and
// the EOP for the serializer from a single clock-divider counter.
module tx_bit_scheduler #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       more,
    input  logic       stuff_req,
    input  logic       abort,
    output logic       busy,
    output logic       load_byte,
    output logic       bit_strobe,
    output logic       stuff_strobe,
    output logic       byte_done,
    output logic [2:0] bit_index,
    output logic       eop_se0,
    output logic       done
);
    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_STUFF,
        S_EOP
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_clk_cnt;
    logic [7:0] w_clk_cnt_nxt;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_nxt;
    logic [1:0] r_eop_ph;
    logic [1:0] w_eop_ph_nxt;
    logic       w_wrap;
    logic [7:0] w_clk_inc;
    logic       w_complete;

    assign w_wrap    = (r_clk_cnt == LAST);
    assign w_clk_inc = w_wrap ? 8'd0 : r_clk_cnt + 8'd1;
    assign busy      = (r_state != S_IDLE);
    assign bit_index = r_bit_cnt;

    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_eop_ph_nxt  = r_eop_ph;
        w_complete    = 1'b0;
        load_byte     = 1'b0;
        bit_strobe    = 1'b0;
        stuff_strobe  = 1'b0;
        byte_done     = 1'b0;
        eop_se0       = 1'b0;
        done          = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_clk_cnt_nxt = 8'd0;
                w_bit_cnt_nxt = 3'd0;
                w_eop_ph_nxt  = 2'd0;
                if (start && !abort) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                load_byte     = 1'b1;
                w_clk_cnt_nxt = 8'd0;
                w_bit_cnt_nxt = 3'd0;
                w_state_nxt   = S_RUN;
            end
            S_RUN: begin
                w_clk_cnt_nxt = w_clk_inc;
                if (w_wrap) begin
                    bit_strobe = 1'b1;
                    if (stuff_req) begin
                        w_state_nxt = S_STUFF;
                    end else if (r_bit_cnt != 3'd7) begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end else begin
                        w_complete = 1'b1;
                    end
                end
            end
            S_STUFF: begin
                w_clk_cnt_nxt = w_clk_inc;
                // the bit advance skipped at the data boundary happens here
                if (w_wrap) begin
                    stuff_strobe = 1'b1;
                    w_state_nxt  = S_RUN;
                    if (r_bit_cnt != 3'd7) begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end else begin
                        w_complete = 1'b1;
                    end
                end
            end
            S_EOP: begin
                eop_se0       = (r_eop_ph != 2'd2);
                w_clk_cnt_nxt = w_clk_inc;
                if (w_wrap) begin
                    if (r_eop_ph == 2'd2) begin
                        done         = 1'b1;
                        w_eop_ph_nxt = 2'd0;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_eop_ph_nxt = r_eop_ph + 2'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_complete) begin
            byte_done     = 1'b1;
            w_bit_cnt_nxt = 3'd0;
            if (more) begin
                load_byte   = 1'b1;
                w_state_nxt = S_RUN;
            end else begin
                w_eop_ph_nxt = 2'd0;
                w_state_nxt  = S_EOP;
            end
        end

        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt   = S_IDLE;
            w_clk_cnt_nxt = 8'd0;
            w_bit_cnt_nxt = 3'd0;
            w_eop_ph_nxt  = 2'd0;
            load_byte     = 1'b0;
            byte_done     = 1'b0;
            done          = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= 8'd0;
            r_bit_cnt <= 3'd0;
            r_eop_ph  <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_eop_ph  <= w_eop_ph_nxt;
        end
    end
endmodule

// File: tb/tb_tx_bit_scheduler.sv
// Scoreboard bench for tx_bit_scheduler: a packet-level timeline model
// predicts every pulse; a negedge monitor pops and compares.
module tb_tx_bit_scheduler;
    localparam int CPB = 8;
    localparam logic [4:0] M_LD  = 5'd1;
    localparam logic [4:0] M_BIT = 5'd2;
    localparam logic [4:0] M_STF = 5'd4;
    localparam logic [4:0] M_BD  = 5'd8;
    localparam logic [4:0] M_DN  = 5'd16;

    typedef struct {
        int         cyc;
        logic [4:0] mask;
        logic [2:0] idx;
    } ev_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       more = 1'b0;
    logic       stuff_req = 1'b0;
    logic       abort = 1'b0;
    logic       busy;
    logic       load_byte;
    logic       bit_strobe;
    logic       stuff_strobe;
    logic       byte_done;
    logic [2:0] bit_index;
    logic       eop_se0;
    logic       done;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   g_busy_lo = 1;
    int   g_busy_hi = 0;
    int   g_se0_lo = 1;
    int   g_se0_hi = 0;
    logic [7:0] g_stuff [0:3];
    ev_t  sb[$];

    tx_bit_scheduler #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .start(start),
        .more(more),
        .stuff_req(stuff_req),
        .abort(abort),
        .busy(busy),
        .load_byte(load_byte),
        .bit_strobe(bit_strobe),
        .stuff_strobe(stuff_strobe),
        .byte_done(byte_done),
        .bit_index(bit_index),
        .eop_se0(eop_se0),
        .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({busy, load_byte, bit_strobe, stuff_strobe,
                    byte_done, eop_se0, done, bit_index});
    endfunction

    logic [4:0] mon_m;
    ev_t        mon_e;
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            mon_m = {done, byte_done, stuff_strobe, bit_strobe, load_byte};
            chk("busy", 32'(busy),
                32'(cyc >= g_busy_lo && cyc <= g_busy_hi));
            if (!abort)
                chk("eop_se0", 32'(eop_se0),
                    32'(cyc >= g_se0_lo && cyc <= g_se0_hi));
            chk("strobe_excl", 32'(bit_strobe & stuff_strobe), 0);
            if (mon_m != 5'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 32'(mon_m), 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pulse_cycle", cyc, mon_e.cyc);
                    chk("pulse_kind", 32'(mon_m), 32'(mon_e.mask));
                    chk("pulse_bit_index", 32'(bit_index), 32'(mon_e.idx));
                end
            end
        end
    end

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // cut < 0: full packet; otherwise abort (or reset) at t0+cut
    task automatic run_packet(input int nb, input int cut,
                              input bit use_rst);
        int         t0;
        int         c;
        int         tdone;
        int         tend;
        int         tcut;
        int         se0_lo;
        int         se0_hi;
        logic [4:0] m;
        logic       last;
        ev_t        evs[$];
        bit         stuffbnd[int];
        bit         more_at[int];
        t0 = cyc;
        c = t0 + 1;
        tcut = 0;
        evs.push_back('{c, M_LD, 3'd0});
        for (int b = 0; b < nb; b++) begin
            last = (b == nb - 1);
            for (int k = 0; k < 8; k++) begin
                c += CPB;
                m = M_BIT;
                stuffbnd[c] = g_stuff[b][k];
                if (k == 7 && !g_stuff[b][k]) begin
                    m = m | M_BD | (last ? 5'd0 : M_LD);
                    more_at[c] = !last;
                end
                evs.push_back('{c, m, 3'(k)});
                if (g_stuff[b][k]) begin
                    c += CPB;
                    m = M_STF;
                    if (k == 7) begin
                        m = m | M_BD | (last ? 5'd0 : M_LD);
                        more_at[c] = !last;
                    end
                    evs.push_back('{c, m, 3'(k)});
                end
            end
        end
        se0_lo = c + 1;
        se0_hi = c + 2 * CPB;
        tdone = c + 3 * CPB;
        evs.push_back('{tdone, M_DN, 3'd0});
        tend = tdone;
        if (cut >= 0) begin
            tcut = t0 + cut;
            tend = tcut;
            if (se0_hi > tcut - 1) se0_hi = tcut - 1;
        end
        foreach (evs[i])
            if (cut < 0 || evs[i].cyc < tcut) sb.push_back(evs[i]);
        g_busy_lo = t0 + 1;
        g_busy_hi = tend;
        g_se0_lo = se0_lo;
        g_se0_hi = se0_hi;
        for (c = t0; c <= tend; c++) begin
            start = (c == t0) ? 1'b1 : 1'($urandom_range(0, 1));
            stuff_req = stuffbnd.exists(c) ? stuffbnd[c]
                                           : 1'($urandom_range(0, 1));
            more = more_at.exists(c) ? more_at[c]
                                     : 1'($urandom_range(0, 1));
            abort = (cut >= 0 && !use_rst && c == tcut);
            if (cut >= 0 && use_rst && c == tcut) begin
                start = 1'b0;
                #2;
                n_rst = 1'b0;
                #1;
                chk("reset_outputs", all_outs(), 0);
                @(posedge clk);
                @(posedge clk);
                #1;
                chk("reset_hold", all_outs(), 0);
                n_rst = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        stuff_req = 1'b0;
        more = 1'b0;
        chk("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic clear_stuff();
        for (int b = 0; b < 4; b++) g_stuff[b] = 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        int len;
        int nst;
        int mode;
        int cut;
        clear_stuff();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", all_outs(), 0);
        n_rst = 1'b1;
        idle(2);

        run_packet(1, -1, 0);
        idle(2);
        run_packet(2, -1, 0);
        idle(2);
        g_stuff[0] = 8'b0000_0010;
        run_packet(1, -1, 0);
        idle(1);
        g_stuff[0] = 8'b1000_0000;
        g_stuff[1] = 8'b1000_0000;
        run_packet(2, -1, 0);
        clear_stuff();
        idle(1);
        run_packet(1, 40, 0);
        run_packet(1, -1, 0);
        idle(1);
        run_packet(1, 1, 0);
        idle(1);
        run_packet(1, 70, 1);
        run_packet(1, -1, 0);
        idle(1);

        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 0);
        idle(1);
        chk("start_abort_idle", all_outs(), 0);

        repeat (25) begin
            clear_stuff();
            nb = $urandom_range(1, 3);
            nst = 0;
            for (int b = 0; b < nb; b++) begin
                g_stuff[b] = 8'($urandom & $urandom & $urandom);
                nst += $countones(g_stuff[b]);
            end
            len = 1 + CPB * (8 * nb + nst) + 3 * CPB;
            cut = 1 + CPB * $urandom_range(0, (len - 1) / CPB - 1)
                + $urandom_range(1, CPB - 1);
            mode = $urandom_range(0, 7);
            if (mode < 2) run_packet(nb, cut, 0);
            else if (mode == 2) run_packet(nb, cut, 1);
            else run_packet(nb, -1, 0);
            idle($urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
